// File: rtl/rec_channel_sequencer_pkg.sv
// Shared types and default sizing for the recording-channel sequencer.
// Widths match the ADC channel and buffer RAM of one measurement lane.
package rec_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int TS_W_DEF       = 13;
    localparam int LEN_W_DEF      = 11;
    localparam int TMO_W_DEF      = 16;
    localparam int SETTLE_CYC_DEF = 300;
    localparam int RAM_DEPTH_DEF  = 1024;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT_ECHO,
        S_SETTLE,
        S_DRAIN,
        S_DONE
    } state_e;

endpackage

// File: rtl/rec_channel_sequencer_if.sv
// Frame descriptor handshake from the sequencer to the host-side reader.
// The master presents a descriptor; the slave accepts it with frame_ready.
interface rec_channel_sequencer_if #(
    parameter int LEN_W = rec_pkg::LEN_W_DEF,
    parameter int TS_W  = rec_pkg::TS_W_DEF
) ();

    logic             frame_valid;
    logic             frame_ready;
    logic [LEN_W-1:0] frame_len;
    logic [TS_W-1:0]  frame_ts;
    logic             frame_timeout;

    modport master (
        output frame_valid,
        output frame_len,
        output frame_ts,
        output frame_timeout,
        input  frame_ready
    );

    modport slave (
        input  frame_valid,
        input  frame_len,
        input  frame_ts,
        input  frame_timeout,
        output frame_ready
    );

endinterface

// File: rtl/rec_drain_engine.sv
// Copies len words from the channel FIFO into buffer RAM starting at 0.
// Reads are issued back to back; each write trails its read by one cycle.
module rec_drain_engine
    import rec_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [DATA_W-1:0] fifo_q_i,
    output logic              rd_req_o,
    output logic              we_o,
    output logic [LEN_W-1:0]  addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              done_o
);

    logic [LEN_W-1:0] rem_q, rem_d;
    logic [LEN_W-1:0] addr_q, addr_d;
    logic             we_q, we_d;
    logic             rd;

    assign rd = (rem_q != '0);

    always_comb begin
        rem_d  = rem_q;
        addr_d = addr_q;
        we_d   = rd;
        if (go_i) begin
            rem_d  = len_i;
            addr_d = '0;
        end else begin
            if (rd) begin
                rem_d = rem_q - 1'b1;
            end
            // advance only when another write follows, so the last address holds
            if (we_q && rd) begin
                addr_d = addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            addr_q <= '0;
            we_q   <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            addr_q <= addr_d;
            we_q   <= we_d;
        end
    end

    assign rd_req_o = rd;
    assign we_o     = we_q;
    assign addr_o   = addr_q;
    assign data_o   = we_q ? fifo_q_i : '0;
    assign done_o   = we_q && !rd;

endmodule

// File: rtl/rec_channel_sequencer.sv
// Per-shot sequencer: arm channel, wait for echo or timeout, settle,
// drain the channel FIFO into buffer RAM and hand a frame to the host.
module rec_channel_sequencer
    import rec_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int TS_W       = TS_W_DEF,
    parameter int LEN_W      = LEN_W_DEF,
    parameter int TMO_W      = TMO_W_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int RAM_DEPTH  = RAM_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cycle_start,
    input  logic [TMO_W-1:0]  timeout_cycles,
    output logic              busy,
    output logic [7:0]        missed_starts,
    output logic              start_pulse,
    output logic              stop_recording,
    input  logic              echo_pulse_detected,
    input  logic [LEN_W-1:0]  sample_length,
    input  logic [TS_W-1:0]   timestamp,
    output logic              fifo_read_request,
    input  logic [DATA_W-1:0] fifo_q,
    output logic              ram_we,
    output logic [LEN_W-1:0]  ram_addr,
    output logic [DATA_W-1:0] ram_d,
    rec_channel_sequencer_if.master frame
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1);

    state_e           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic [SET_W-1:0] scnt_q, scnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic             to_q, to_d;
    logic [7:0]       miss_q, miss_d;

    logic [TMO_W-1:0] cnt_inc;
    logic             expired;
    logic             settle_last;
    logic [LEN_W-1:0] len_clamp;
    logic             drain_go;
    logic             drain_done;

    // wait cycle k (from 0) sees count k+1; a zero limit expires at once
    assign cnt_inc     = cnt_q + 1'b1;
    assign expired     = (cnt_inc == tmo_q) || (tmo_q == '0);
    assign settle_last = (scnt_q == SET_W'(SETTLE_CYC - 1));
    assign drain_go    = (state_q == S_SETTLE) && settle_last
                         && (len_clamp != '0);

    always_comb begin
        len_clamp = sample_length;
        if (int'(sample_length) > RAM_DEPTH) begin
            len_clamp = LEN_W'(RAM_DEPTH);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (cycle_start) state_d = S_ARM;
            end
            S_ARM: begin
                state_d = S_WAIT_ECHO;
            end
            S_WAIT_ECHO: begin
                if (echo_pulse_detected || expired) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_last) begin
                    state_d = (len_clamp == '0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_done) state_d = S_DONE;
            end
            S_DONE: begin
                if (frame.frame_ready) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy               = (state_q != S_IDLE);
        start_pulse        = (state_q == S_ARM);
        stop_recording     = (state_q == S_WAIT_ECHO)
                             && !echo_pulse_detected && expired;
        frame.frame_valid  = (state_q == S_DONE);
        frame.frame_len    = len_q;
        frame.frame_ts     = ts_q;
        frame.frame_timeout = to_q;
        missed_starts      = miss_q;
    end

    always_comb begin
        tmo_d  = tmo_q;
        cnt_d  = cnt_q;
        scnt_d = scnt_q;
        len_d  = len_q;
        ts_d   = ts_q;
        to_d   = to_q;
        miss_d = miss_q;
        if (state_q == S_IDLE && cycle_start) begin
            tmo_d = timeout_cycles;
        end
        if (state_q == S_ARM) begin
            cnt_d = '0;
        end
        if (state_q == S_WAIT_ECHO) begin
            cnt_d  = cnt_inc;
            scnt_d = '0;
            to_d   = !echo_pulse_detected && expired;
        end
        if (state_q == S_SETTLE) begin
            scnt_d = scnt_q + 1'b1;
            if (settle_last) begin
                len_d = len_clamp;
                ts_d  = timestamp;
            end
        end
        if (state_q != S_IDLE && cycle_start && miss_q != 8'hFF) begin
            miss_d = miss_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_q  <= '0;
            cnt_q  <= '0;
            scnt_q <= '0;
            len_q  <= '0;
            ts_q   <= '0;
            to_q   <= 1'b0;
            miss_q <= '0;
        end else begin
            tmo_q  <= tmo_d;
            cnt_q  <= cnt_d;
            scnt_q <= scnt_d;
            len_q  <= len_d;
            ts_q   <= ts_d;
            to_q   <= to_d;
            miss_q <= miss_d;
        end
    end

    rec_drain_engine #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_drain (
        .clk      (clk),
        .rst_n    (reset),
        .go_i     (drain_go),
        .len_i    (len_clamp),
        .fifo_q_i (fifo_q),
        .rd_req_o (fifo_read_request),
        .we_o     (ram_we),
        .addr_o   (ram_addr),
        .data_o   (ram_d),
        .done_o   (drain_done)
    );

endmodule

// File: tb/tb_rec_channel_sequencer.sv
// Scoreboard bench for rec_channel_sequencer: directed shots queue expected
// RAM writes and frames; a negedge monitor pops and compares them.
module tb_rec_channel_sequencer;
    import rec_pkg::*;

    localparam int DW = 8;
    localparam int TW = 13;
    localparam int LW = 11;
    localparam int MW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cycle_start = 1'b0;
    logic [MW-1:0] timeout_cycles = '0;
    logic          busy;
    logic [7:0]    missed_starts;
    logic          start_pulse;
    logic          stop_recording;
    logic          echo_pulse_detected = 1'b0;
    logic [LW-1:0] sample_length = '0;
    logic [TW-1:0] timestamp = '0;
    logic          fifo_read_request;
    logic [DW-1:0] fifo_q = '0;
    logic          ram_we;
    logic [LW-1:0] ram_addr;
    logic [DW-1:0] ram_d;

    rec_channel_sequencer_if #(.LEN_W(LW), .TS_W(TW)) fif ();

    always #5 clk = ~clk;

    rec_channel_sequencer #(
        .DATA_W(DW), .TS_W(TW), .LEN_W(LW), .TMO_W(MW),
        .SETTLE_CYC(300), .RAM_DEPTH(1024)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .cycle_start         (cycle_start),
        .timeout_cycles      (timeout_cycles),
        .busy                (busy),
        .missed_starts       (missed_starts),
        .start_pulse         (start_pulse),
        .stop_recording      (stop_recording),
        .echo_pulse_detected (echo_pulse_detected),
        .sample_length       (sample_length),
        .timestamp           (timestamp),
        .fifo_read_request   (fifo_read_request),
        .fifo_q              (fifo_q),
        .ram_we              (ram_we),
        .ram_addr            (ram_addr),
        .ram_d               (ram_d),
        .frame               (fif)
    );

    int n_chk = 0;
    int n_pass = 0;

    function automatic logic [7:0] fdat(int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    task automatic check(string nm, longint got, longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    // channel FIFO model: data appears one cycle after each read request
    logic fifo_clr = 1'b0;
    int   fifo_idx = 0;
    always @(posedge clk) begin
        if (fifo_clr) begin
            fifo_idx <= 0;
        end else if (fifo_read_request) begin
            fifo_q   <= fdat(fifo_idx);
            fifo_idx <= fifo_idx + 1;
        end
    end

    typedef struct {
        int len;
        int ts;
        int to;
    } fr_t;

    fr_t        fq[$];
    int         wq_addr[$];
    logic [7:0] wq_dat[$];

    int         cyc = 0;
    int         start_cyc = 0;
    int         stop_cyc = 0;
    int         stop_cnt = 0;
    int         rd_total = 0;
    int         m_a;
    logic [7:0] m_d;
    fr_t        m_f;

    always @(negedge clk) begin
        cyc++;
        if (start_pulse) start_cyc = cyc;
        if (stop_recording) begin
            stop_cyc = cyc;
            stop_cnt++;
        end
        if (fifo_read_request) rd_total++;
        if (ram_we) begin
            if (wq_addr.size() == 0) begin
                check("unexpected_ram_we", 1, 0);
            end else begin
                m_a = wq_addr.pop_front();
                m_d = wq_dat.pop_front();
                check("ram_addr", ram_addr, m_a);
                check("ram_d", ram_d, m_d);
            end
        end
        if (fif.frame_valid && fif.frame_ready) begin
            if (fq.size() == 0) begin
                check("unexpected_frame", 1, 0);
            end else begin
                m_f = fq.pop_front();
                check("frame_len", fif.frame_len, m_f.len);
                check("frame_ts", fif.frame_ts, m_f.ts);
                check("frame_timeout", fif.frame_timeout, m_f.to);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_start"}, start_pulse, 0);
        check({tag, "_stop"}, stop_recording, 0);
        check({tag, "_rdreq"}, fifo_read_request, 0);
        check({tag, "_we"}, ram_we, 0);
        check({tag, "_addr"}, ram_addr, 0);
        check({tag, "_d"}, ram_d, 0);
        check({tag, "_fvalid"}, fif.frame_valid, 0);
        check({tag, "_flen"}, fif.frame_len, 0);
        check({tag, "_missed"}, missed_starts, 0);
    endtask

    task automatic recover();
        reset = 1'b0;
        tick();
        wq_addr.delete();
        wq_dat.delete();
        fq.delete();
        echo_pulse_detected = 1'b0;
        cycle_start = 1'b0;
        fif.frame_ready = 1'b0;
        reset = 1'b1;
        tick();
    endtask

    // echo_k < 0: no echo; otherwise echo rises k cycles after start_pulse
    task automatic run(input string nm, input int tmo, input int echo_k,
                       input int slen, input int ts, input int hold,
                       input int extra);
        int  exp_len, eff, exp_to, rd0, st0, k;
        fr_t f;
        exp_len = (slen > 1024) ? 1024 : slen;
        eff     = (tmo == 0) ? 1 : tmo;
        exp_to  = (echo_k < 0 || echo_k > eff) ? 1 : 0;
        for (int i = 0; i < exp_len; i++) begin
            wq_addr.push_back(i);
            wq_dat.push_back(fdat(i));
        end
        f.len = exp_len;
        f.ts  = ts;
        f.to  = exp_to;
        fq.push_back(f);
        rd0 = rd_total;
        st0 = stop_cnt;
        sample_length  = LW'(slen);
        timestamp      = TW'(ts);
        timeout_cycles = MW'(tmo);
        fifo_clr    = 1'b1;
        cycle_start = 1'b1;
        tick();
        fifo_clr    = 1'b0;
        cycle_start = 1'b0;
        check({nm, "_start_pulse"}, start_pulse, 1);
        if (echo_k >= 0) begin
            repeat (echo_k) tick();
            echo_pulse_detected = 1'b1;
        end
        k = 0;
        while (!fif.frame_valid && k < 4000) begin
            tick();
            k++;
        end
        echo_pulse_detected = 1'b0;
        if (!fif.frame_valid) begin
            check({nm, "_frame_wait_expired"}, 0, 1);
            recover();
            return;
        end
        for (int i = 0; i < hold; i++) begin
            check({nm, "_hold_valid"}, fif.frame_valid, 1);
            check({nm, "_hold_busy"}, busy, 1);
            check({nm, "_hold_len"}, fif.frame_len, exp_len);
            check({nm, "_hold_ts"}, fif.frame_ts, ts);
            check({nm, "_hold_to"}, fif.frame_timeout, exp_to);
            cycle_start = (extra > 0) && (i % 10 == 5) && (i < 10 * extra);
            tick();
        end
        cycle_start = 1'b0;
        if (extra > 0) check({nm, "_missed_starts"}, missed_starts, extra);
        fif.frame_ready = 1'b1;
        tick();
        fif.frame_ready = 1'b0;
        check({nm, "_idle_after_ack"}, busy, 0);
        check({nm, "_valid_drop"}, fif.frame_valid, 0);
        check({nm, "_reads"}, rd_total - rd0, exp_len);
        check({nm, "_stop_count"}, stop_cnt - st0, exp_to);
        if (exp_to == 1) begin
            check({nm, "_stop_delay"}, stop_cyc - start_cyc, eff);
        end
        tick();
    endtask

    initial begin
        int k;
        fif.frame_ready = 1'b0;
        repeat (3) tick();
        check_idle("reset");
        reset = 1'b1;
        tick();

        run("backpressure", 5000, 20, 16, 'h123, 50, 3);
        run("echo", 5000, 400, 256, 'h0A5, 0, 0);
        run("timeout", 1000, -1, 100, 'h1FF, 0, 0);
        run("len0", 5000, 10, 0, 'h0F0, 3, 0);
        run("clamp", 5000, 10, 2000, 'h1ABC, 0, 0);
        run("simul", 1000, 1000, 8, 'h077, 0, 0);
        run("tmo0", 0, -1, 4, 'h011, 0, 0);

        // abort mid-drain at word 40, then a clean shot from address 0
        for (int i = 0; i < 100; i++) begin
            wq_addr.push_back(i);
            wq_dat.push_back(fdat(i));
        end
        sample_length  = LW'(100);
        timestamp      = TW'('h33);
        timeout_cycles = MW'(5000);
        fifo_clr    = 1'b1;
        cycle_start = 1'b1;
        tick();
        fifo_clr    = 1'b0;
        cycle_start = 1'b0;
        repeat (5) tick();
        echo_pulse_detected = 1'b1;
        k = 0;
        while (!(ram_we && ram_addr == LW'(40)) && k < 2000) begin
            tick();
            k++;
        end
        check("abort_reached_word40", ram_addr, 40);
        reset = 1'b0;
        #1;
        check_idle("abort");
        echo_pulse_detected = 1'b0;
        wq_addr.delete();
        wq_dat.delete();
        tick();
        tick();
        reset = 1'b1;
        tick();
        run("after_abort", 5000, 10, 20, 'h055, 0, 0);

        check("write_queue_empty", wq_addr.size(), 0);
        check("frame_queue_empty", fq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
